// File: rtl/minterm_sweeper.sv
// -----------------------------------------------------------------------------
// minterm_sweeper
//   Drives a 4-input combinational function under test through all 16
//   minterms, in binary or Gray order. It samples f once per minterm, builds
//   the measured truth table and compares it with an expected table that is
//   captured when a sweep starts.
//
// Parameters
//   SETTLE : cycles each vector is held before f is sampled (1..15)
//   GRAY   : 0 = binary minterm order, 1 = Gray-code order
//
// Ports
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   start          : single-cycle sweep request, honoured only in IDLE
//   expect_tt[15:0]: expected truth table (bit m = f for minterm m)
//   f              : output of the function under test
//   a, b, c, d     : registered drive vector, a = MSB of the minterm
//   busy           : high while a sweep is running
//   done           : one-cycle pulse when a sweep completes
//   pass           : tt == captured expectation, valid from done until next start
//   tt[15:0]       : measured truth table, indexed by minterm value
//   mismatch_cnt   : number of mismatching minterms (0..16)
//   mismatch_idx   : lowest mismatching minterm, 0 when there is none
// -----------------------------------------------------------------------------
module minterm_sweeper #(
  parameter int SETTLE = 2,
  parameter int GRAY   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expect_tt,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] tt,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  mismatch_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Value of the settle counter on the cycle whose closing edge samples f.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  // Maps a step number onto the minterm driven during that step.
  function automatic logic [3:0] minterm_of(input logic [3:0] k);
    logic [3:0] m;
    if (GRAY != 0) begin
      m = k ^ {1'b0, k[3:1]};
    end else begin
      m = k;
    end
    return m;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  vec_q, vec_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  mcnt_q, mcnt_d;
  logic [3:0]  midx_q, midx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  cur_m_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= 4'd0;
      cnt_q   <= 4'd0;
      vec_q   <= 4'd0;
      exp_q   <= 16'd0;
      tt_q    <= 16'd0;
      mcnt_q  <= 5'd0;
      midx_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      mcnt_q  <= mcnt_d;
      midx_q  <= midx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and datapath update for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    mcnt_d  = mcnt_q;
    midx_d  = midx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    cur_m_s = minterm_of(step_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          exp_d   = expect_tt;
          tt_d    = 16'd0;
          mcnt_d  = 5'd0;
          midx_d  = 4'd0;
          pass_d  = 1'b0;
          step_d  = 4'd0;
          cnt_d   = 4'd0;
          vec_d   = minterm_of(4'd0);
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (cnt_q == SETTLE_LAST) begin
          tt_d[cur_m_s] = f;
          if (f != exp_q[cur_m_s]) begin
            mcnt_d = mcnt_q + 5'd1;
            // Gray order can visit a higher minterm first, so keep the minimum
            // minterm value rather than the first one seen.
            if ((mcnt_q == 5'd0) || (cur_m_s < midx_q)) begin
              midx_d = cur_m_s;
            end else begin
              midx_d = midx_q;
            end
          end else begin
            mcnt_d = mcnt_q;
          end
          if (step_q == 4'd15) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            vec_d   = 4'd0;
            pass_d  = (tt_d == exp_q);
          end else begin
            step_d = step_q + 4'd1;
            cnt_d  = 4'd0;
            vec_d  = minterm_of(step_q + 4'd1);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        vec_d   = 4'd0;
      end
    endcase
  end

  assign a            = vec_q[3];
  assign b            = vec_q[2];
  assign c            = vec_q[1];
  assign d            = vec_q[0];
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign tt           = tt_q;
  assign mismatch_cnt = mcnt_q;
  assign mismatch_idx = midx_q;

endmodule

// File: tb/tb_minterm_sweeper.sv
// -----------------------------------------------------------------------------
// tb_minterm_sweeper
//   Two instances: a binary-order sweeper (SETTLE=3) and a Gray-order sweeper
//   (SETTLE=2). Stimulus tasks push hand-computed results into per-instance
//   queues; monitors pop and compare whenever an instance pulses done.
// -----------------------------------------------------------------------------
module tb_minterm_sweeper;

  typedef struct packed {
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic [3:0]  idx;
    logic        pass;
  } res_t;

  logic clk;
  logic rst_n;

  // Binary-order instance
  logic        start_b, f_b, fzero;
  logic [15:0] exp_b;
  logic        a_b, b_b, c_b, d_b, busy_b, done_b, pass_b;
  logic [15:0] tt_b;
  logic [4:0]  mcnt_b;
  logic [3:0]  midx_b;

  // Gray-order instance
  logic        start_g, f_g;
  logic [15:0] exp_g;
  logic        a_g, b_g, c_g, d_g, busy_g, done_g, pass_g;
  logic [15:0] tt_g;
  logic [4:0]  mcnt_g;
  logic [3:0]  midx_g;

  int checks   = 0;
  int failures = 0;

  res_t q_b[$];
  res_t q_g[$];
  logic done_b_prev = 1'b0;
  logic done_g_prev = 1'b0;

  logic [3:0] gseq [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                            4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  assign f_b = fzero ? 1'b0 : (a_b ^ b_b ^ c_b ^ d_b);
  assign f_g = a_g ^ b_g ^ c_g ^ d_g;

  minterm_sweeper #(.SETTLE(3), .GRAY(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expect_tt(exp_b), .f(f_b),
    .a(a_b), .b(b_b), .c(c_b), .d(d_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .tt(tt_b), .mismatch_cnt(mcnt_b), .mismatch_idx(midx_b)
  );

  minterm_sweeper #(.SETTLE(2), .GRAY(1)) dut_g (
    .clk(clk), .rst_n(rst_n), .start(start_g), .expect_tt(exp_g), .f(f_g),
    .a(a_g), .b(b_g), .c(c_g), .d(d_g), .busy(busy_g), .done(done_g),
    .pass(pass_g), .tt(tt_g), .mismatch_cnt(mcnt_g), .mismatch_idx(midx_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor for the binary instance.
  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      check("b_done_width", 32'(done_b_prev), 32'd0);
      check("b_sb_pending", 32'(q_b.size() > 0), 32'd1);
      if (q_b.size() > 0) begin
        res_t r;
        r = q_b.pop_front();
        check("b_tt",   32'(tt_b),   32'(r.tt));
        check("b_cnt",  32'(mcnt_b), 32'(r.cnt));
        check("b_idx",  32'(midx_b), 32'(r.idx));
        check("b_pass", 32'(pass_b), 32'(r.pass));
      end
    end
    done_b_prev = done_b;
  end

  // Scoreboard monitor for the Gray instance.
  always @(negedge clk) begin
    if (done_g === 1'b1) begin
      check("g_done_width", 32'(done_g_prev), 32'd0);
      check("g_sb_pending", 32'(q_g.size() > 0), 32'd1);
      if (q_g.size() > 0) begin
        res_t r;
        r = q_g.pop_front();
        check("g_tt",   32'(tt_g),   32'(r.tt));
        check("g_cnt",  32'(mcnt_g), 32'(r.cnt));
        check("g_idx",  32'(midx_g), 32'(r.idx));
        check("g_pass", 32'(pass_g), 32'(r.pass));
      end
    end
    done_g_prev = done_g;
  end

  // Binary sweep, called at a negedge. abuse pulses start at steps 2, 9 and
  // in the DONE cycle, and scrambles expect_tt mid-sweep.
  task automatic run_bin(input logic [15:0] exp, input logic fz, input bit abuse, input res_t r);
    int errs;
    errs = 0;
    exp_b = exp; fzero = fz; start_b = 1'b1;
    q_b.push_back(r);
    @(negedge clk);
    start_b = 1'b0;
    for (int j = 0; j < 48; j++) begin
      if (({a_b, b_b, c_b, d_b} !== 4'(j / 3)) || (busy_b !== 1'b1) || (done_b !== 1'b0)) errs++;
      if (abuse) begin
        start_b = ((j == 6) || (j == 27)) ? 1'b1 : 1'b0;
        if (j == 10) exp_b = ~exp;
      end
      @(negedge clk);
    end
    start_b = 1'b0;
    check("b_drive_seq", 32'(errs), 32'd0);
    check("b_done_at_end", 32'(done_b), 32'd1);
    check("b_busy_at_end", 32'(busy_b), 32'd0);
    check("b_vec_at_end", 32'({a_b, b_b, c_b, d_b}), 32'd0);
    if (abuse) start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_no_restart", 32'(busy_b), 32'd0);
  endtask

  // Gray sweep (SETTLE=2), called at a negedge.
  task automatic run_gray(input logic [15:0] exp, input res_t r);
    int errs;
    int tog;
    logic [3:0] prev;
    logic [3:0] cur;
    errs = 0; tog = 0; prev = 4'd0;
    exp_g = exp; start_g = 1'b1;
    q_g.push_back(r);
    @(negedge clk);
    start_g = 1'b0;
    for (int j = 0; j < 32; j++) begin
      cur = {a_g, b_g, c_g, d_g};
      if ((cur !== gseq[j / 2]) || (busy_g !== 1'b1)) errs++;
      if ((j > 0) && ((j % 2) == 0) && ($countones(cur ^ prev) != 1)) tog++;
      prev = cur;
      @(negedge clk);
    end
    check("g_drive_seq", 32'(errs), 32'd0);
    check("g_one_toggle", 32'(tog), 32'd0);
    check("g_done_at_end", 32'(done_g), 32'd1);
    check("g_vec_at_end", 32'({a_g, b_g, c_g, d_g}), 32'd0);
    @(negedge clk);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_b = 1'b0; start_g = 1'b0;
    exp_b = 16'd0; exp_g = 16'd0; fzero = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vec_b",  32'({a_b, b_b, c_b, d_b}), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_done_b", 32'(done_b), 32'd0);
    check("rst_pass_b", 32'(pass_b), 32'd0);
    check("rst_tt_b",   32'(tt_b),   32'd0);
    check("rst_cnt_b",  32'(mcnt_b), 32'd0);
    check("rst_idx_b",  32'(midx_b), 32'd0);
    check("rst_busy_g", 32'(busy_g), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_bin(16'h6996, 1'b0, 1'b0, '{tt: 16'h6996, cnt: 5'd0,  idx: 4'd0,  pass: 1'b1});
    // Next start lands in the IDLE cycle right after DONE.
    run_bin(16'h6997, 1'b0, 1'b0, '{tt: 16'h6996, cnt: 5'd1,  idx: 4'd0,  pass: 1'b0});
    check("hold_tt",   32'(tt_b),   32'h6996);
    check("hold_cnt",  32'(mcnt_b), 32'd1);
    check("hold_pass", 32'(pass_b), 32'd0);
    run_bin(16'hE996, 1'b0, 1'b0, '{tt: 16'h6996, cnt: 5'd1,  idx: 4'd15, pass: 1'b0});
    run_bin(16'hFFFF, 1'b1, 1'b0, '{tt: 16'h0000, cnt: 5'd16, idx: 4'd0,  pass: 1'b0});
    run_bin(16'h6996, 1'b0, 1'b1, '{tt: 16'h6996, cnt: 5'd0,  idx: 4'd0,  pass: 1'b1});

    run_gray(16'h6996, '{tt: 16'h6996, cnt: 5'd0, idx: 4'd0, pass: 1'b1});
    // Minterms 8 and 10 wrong; Gray order meets 10 first, lowest is still 8.
    run_gray(16'h6C96, '{tt: 16'h6996, cnt: 5'd2, idx: 4'd8, pass: 1'b0});

    // Reset during step 5 of a binary sweep: no result is expected from it.
    @(negedge clk);
    exp_b = 16'h6997; fzero = 1'b0; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (16) @(negedge clk);
    check("pre_rst_tt",  32'(tt_b),   32'h0016);
    check("pre_rst_cnt", 32'(mcnt_b), 32'd1);
    check("pre_rst_vec", 32'({a_b, b_b, c_b, d_b}), 32'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vec",  32'({a_b, b_b, c_b, d_b}), 32'd0);
    check("mid_rst_busy", 32'(busy_b), 32'd0);
    check("mid_rst_tt",   32'(tt_b),   32'd0);
    check("mid_rst_cnt",  32'(mcnt_b), 32'd0);
    check("mid_rst_done", 32'(done_b), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    run_bin(16'h6996, 1'b0, 1'b0, '{tt: 16'h6996, cnt: 5'd0, idx: 4'd0, pass: 1'b1});

    repeat (3) @(negedge clk);
    check("sb_b_drained", 32'(q_b.size()), 32'd0);
    check("sb_g_drained", 32'(q_g.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
